// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO feeding the integer regfile write port, with a pending-destination mask.
// Optional operand bypass from queued entries is enabled by defining WB_FORWARD_EN.
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    output logic            rf_write,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic [31:0]     pend_mask,
    output logic            empty,
    output logic            full
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]      fwd_rs1,
    input  logic [4:0]      fwd_rs2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic [CW-1:0]   free;
    logic            mem_push, alu_push, pop;
    logic [PW-1:0]   alu_slot;

    assign free  = DEPTH_C - count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // Readiness uses only the registered count; rst_n gating keeps both low while in reset.
    assign mem_ready = rst_n && !flush && (free >= CW'(1));
    assign alu_ready = rst_n && !flush &&
                       ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));

    // Results targeting x0 complete their handshake but never occupy a slot.
    assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign pop      = !empty;
    assign alu_slot = wr_ptr_q + PW'(mem_push);

    assign rf_write   = !empty;
    assign rf_wr_addr = empty ? 5'd0 : rd_q[rd_ptr_q];
    assign rf_wr_data = empty ? '0 : data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            vld_d    = '0;
        end else begin
            if (pop) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = rd_ptr_q + 1'b1;
            end
            if (mem_push) vld_d[wr_ptr_q] = 1'b1;
            if (alu_push) vld_d[alu_slot] = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
            count_d  = count_q - CW'(pop) + CW'(mem_push) + CW'(alu_push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_q[wr_ptr_q]   <= mem_rd;
            data_q[wr_ptr_q] <= mem_data;
        end
        if (alu_push) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pend_mask[rd_q[i]] = 1'b1;
        end
    end

`ifdef WB_FORWARD_EN
    logic [PW-1:0] fidx;

    // Walk from head to tail so the youngest matching entry wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        fidx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = rd_ptr_q + PW'(k);
            if (vld_q[fidx] && (fwd_rs1 != 5'd0) && (rd_q[fidx] == fwd_rs1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = data_q[fidx];
            end
            if (vld_q[fidx] && (fwd_rs2 != 5'd0) && (rd_q[fidx] == fwd_rs2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = data_q[fidx];
            end
        end
    end
`endif

endmodule
